// File: rtl/fft_pkg.sv
// Shared constants and FSM state type for the radix-2 FFT address generator.
// Default size is a 32-point transform.
package fft_pkg;

  localparam int LOG2N        = 5;
  localparam int N            = 1 << LOG2N;
  localparam int NUM_STAGES   = LOG2N;
  localparam int BF_PER_STAGE = N / 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fft_stage_cnt.sv
// Modulo-MOD stage counter with enable and synchronous clear.
// Exposes the next value so callers can register data aligned to it.
module fft_stage_cnt #(
  parameter int MOD = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  output logic [2:0] cnt_q,
  output logic [2:0] cnt_d,
  output logic       wrap
);

  assign wrap = en & (cnt_q == 3'(MOD - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 3'd0;
    end else if (en) begin
      cnt_d = wrap ? 3'd0 : cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fft_addr_gen.sv
// In-place radix-2 FFT butterfly address and twiddle index generator.
// Outputs are registered from the next-cycle counter values.
module fft_addr_gen #(
  parameter int LOG2N = fft_pkg::LOG2N
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sclr,
  input  logic             bf_ready,
  output logic [LOG2N-1:0] addr_a,
  output logic [LOG2N-1:0] addr_b,
  output logic [LOG2N-2:0] tw_idx,
  output logic [2:0]       stage,
  output logic             valid,
  output logic             stage_done,
  output logic             busy,
  output logic             done
);

  import fft_pkg::*;

  localparam int JW = LOG2N - 1;
  localparam logic [JW-1:0] J_LAST = '1;

  state_e state_q, state_d;

  logic [JW-1:0] j_q, j_d;
  logic [2:0]    s_q, s_d;
  logic          s_wrap;
  logic          acc;
  logic          last_bf;
  logic          s_clr;
  logic          s_en;

  logic [LOG2N-1:0] addr_a_q, addr_a_d;
  logic [LOG2N-1:0] addr_b_q, addr_b_d;
  logic [JW-1:0]    tw_q, tw_d;
  logic [2:0]       stage_q, stage_d;
  logic             valid_q, valid_d;
  logic             sdone_q, sdone_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [LOG2N-1:0] jx;
  logic [LOG2N-1:0] mask;

  assign acc     = valid_q & bf_ready;
  assign last_bf = (j_q == J_LAST);
  assign s_en    = acc & last_bf;
  assign s_clr   = sclr | (state_q != ST_RUN);

  fft_stage_cnt #(
    .MOD (LOG2N)
  ) u_stage_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (s_clr),
    .en    (s_en),
    .cnt_q (s_q),
    .cnt_d (s_d),
    .wrap  (s_wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (sclr) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: if (start) state_d = ST_RUN;
        ST_RUN:  if (s_wrap) state_d = ST_DONE;
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // j only moves on acceptance; the wrap falls out of the counter width
  always_comb begin
    j_d = j_q;
    if (sclr || state_q != ST_RUN) begin
      j_d = '0;
    end else if (acc) begin
      j_d = j_q + 1'b1;
    end
  end

  always_comb begin
    jx       = {1'b0, j_d};
    mask     = (LOG2N'(1) << s_d) - LOG2N'(1);
    addr_a_d = ((jx >> s_d) << (s_d + 3'd1)) | (jx & mask);
    addr_b_d = addr_a_d | (LOG2N'(1) << s_d);
    tw_d     = (j_d & mask[JW-1:0]) << (3'(JW) - s_d);
    stage_d  = s_d;
    valid_d  = (state_d == ST_RUN);
    busy_d   = (state_d == ST_RUN);
    sdone_d  = !sclr && s_en;
    done_d   = !sclr && (state_q == ST_DONE);
    if (!valid_d) begin
      addr_a_d = '0;
      addr_b_d = '0;
      tw_d     = '0;
      stage_d  = 3'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      j_q      <= '0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      tw_q     <= '0;
      stage_q  <= 3'd0;
      valid_q  <= 1'b0;
      sdone_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      j_q      <= j_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      tw_q     <= tw_d;
      stage_q  <= stage_d;
      valid_q  <= valid_d;
      sdone_q  <= sdone_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign addr_a     = addr_a_q;
  assign addr_b     = addr_b_q;
  assign tw_idx     = tw_q;
  assign stage      = stage_q;
  assign valid      = valid_q;
  assign stage_done = sdone_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_fft_addr_gen.sv
// Directed bench for fft_addr_gen: full passes, stalls, abort and reset.
// Expected beats come from a bit-insertion model and a hand-computed table.
module tb_fft_addr_gen;

  localparam int LW    = 5;
  localparam int BF    = 16;
  localparam int BEATS = 80;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          sclr = 1'b0;
  logic          bf_ready = 1'b0;
  logic [LW-1:0] addr_a;
  logic [LW-1:0] addr_b;
  logic [LW-2:0] tw_idx;
  logic [2:0]    stage;
  logic          valid;
  logic          stage_done;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;
  int cap_a[BEATS];
  int cap_b[BEATS];
  int cap_t[BEATS];

  typedef struct {
    int s;
    int j;
    int a;
    int b;
    int tw;
  } vec_t;

  vec_t tbl[7];

  always #5 clk = ~clk;

  fft_addr_gen #(.LOG2N(LW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .sclr       (sclr),
    .bf_ready   (bf_ready),
    .addr_a     (addr_a),
    .addr_b     (addr_b),
    .tw_idx     (tw_idx),
    .stage      (stage),
    .valid      (valid),
    .stage_done (stage_done),
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model(input int s, input int j,
                                output int a, output int b,
                                output int tw);
    a = 0;
    for (int i = 0; i < LW; i++) begin
      if (i < s) a |= ((j >> i) & 1) << i;
      else if (i > s) a |= ((j >> (i - 1)) & 1) << i;
    end
    b  = a + (1 << s);
    tw = (j % (1 << s)) * (1 << (LW - 1 - s));
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_addr_a"}, addr_a, 0);
    chk({tag, "_addr_b"}, addr_b, 0);
    chk({tag, "_tw"}, tw_idx, 0);
    chk({tag, "_stage"}, stage, 0);
  endtask

  task automatic run_pass(input bit stall, input bit poke,
                          input bit timing);
    int k = 0;
    int sd = 0;
    int dn = 0;
    int done_at = 0;
    int ea, eb, et;
    bit hold = 0;
    int pa = 0, pb = 0, pt = 0, ps = 0;
    @(negedge clk);
    start = 1'b1;
    bf_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= 600; n++) begin
      if (n == 1) chk("first_valid", valid, 1);
      if (hold) begin
        chk("stall_valid", valid, 1);
        chk("stall_a", addr_a, pa);
        chk("stall_b", addr_b, pb);
        chk("stall_tw", tw_idx, pt);
        chk("stall_stage", stage, ps);
        hold = 0;
      end
      if (stage_done) sd++;
      if (done) begin
        dn++;
        if (done_at == 0) done_at = n;
      end
      if (poke && n == 20) start = 1'b1;
      else if (poke && stage_done && k == BEATS) start = 1'b1;
      else start = 1'b0;
      bf_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (valid && bf_ready) begin
        if (k >= BEATS) begin
          chk("extra_beat", k, BEATS - 1);
        end else begin
          model(k / BF, k % BF, ea, eb, et);
          chk("beat_stage", stage, k / BF);
          chk("beat_a", addr_a, ea);
          chk("beat_b", addr_b, eb);
          chk("beat_tw", tw_idx, et);
          chk("beat_busy", busy, 1);
          cap_a[k] = addr_a;
          cap_b[k] = addr_b;
          cap_t[k] = tw_idx;
        end
        k++;
      end else if (valid) begin
        hold = 1;
        pa = addr_a;
        pb = addr_b;
        pt = tw_idx;
        ps = stage;
      end
      if (done_at != 0 && n >= done_at + 4) break;
      @(negedge clk);
    end
    start = 1'b0;
    chk("beat_count", k, BEATS);
    chk("stage_done_count", sd, 5);
    chk("done_count", dn, 1);
    if (timing) chk("done_latency", done_at, 82);
    chk("post_busy", busy, 0);
    chk("post_valid", valid, 0);
  endtask

  initial begin
    int found;

    tbl[0] = '{0, 0, 0, 1, 0};
    tbl[1] = '{0, 15, 30, 31, 0};
    tbl[2] = '{1, 0, 0, 2, 0};
    tbl[3] = '{1, 1, 1, 3, 8};
    tbl[4] = '{2, 5, 9, 13, 4};
    tbl[5] = '{3, 7, 7, 15, 14};
    tbl[6] = '{4, 15, 15, 31, 15};

    #1 rst_n = 1'b0;
    #1;
    chk_idle("reset_async");
    chk("reset_stage_done", stage_done, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("idle_after_reset");

    run_pass(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      int idx;
      idx = tbl[i].s * BF + tbl[i].j;
      chk($sformatf("tbl%0d_a", i), cap_a[idx], tbl[i].a);
      chk($sformatf("tbl%0d_b", i), cap_b[idx], tbl[i].b);
      chk($sformatf("tbl%0d_tw", i), cap_t[idx], tbl[i].tw);
    end

    run_pass(1'b1, 1'b0, 1'b0);
    run_pass(1'b0, 1'b1, 1'b1);

    // abort at stage 3, j=7 (addr_a=7 in that stage)
    @(negedge clk);
    start = 1'b1;
    bf_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int n = 0; n < 200; n++) begin
      if (valid && stage == 3 && addr_a == 7) begin
        found = 1;
        sclr = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("sclr_point_found", found, 1);
    @(negedge clk);
    sclr = 1'b0;
    chk_idle("after_sclr");
    chk("after_sclr_sdone", stage_done, 0);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (done || valid) chk("sclr_quiet", {done, valid}, 0);
    end
    run_pass(1'b0, 1'b0, 1'b1);

    // reset mid-pass
    @(negedge clk);
    start = 1'b1;
    bf_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_idle("rst_mid_async");
    repeat (2) @(negedge clk);
    chk_idle("rst_mid_held");
    rst_n = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (done || valid) chk("rst_quiet", {done, valid}, 0);
    end
    chk_idle("rst_idle");
    run_pass(1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
